// File: rtl/cred_scroll_ctl.sv
`default_nettype none
// ============================================================================
// Module  : cred_scroll_ctl
// Brief   : Credits-screen sequencer: scroll -> hold -> done with pause/skip,
//           driving text block position and cycling text colour.
// Revision: 1.0 - initial release
// ============================================================================
module cred_scroll_ctl #(
    parameter logic [11:0] X_POS        = 12'd400,
    parameter logic [11:0] START_Y      = 12'd600,
    parameter logic [11:0] STOP_Y       = 12'd200,
    parameter int unsigned STEP         = 4,
    parameter int unsigned HOLD_FRAMES  = 120,
    parameter int unsigned COLOR_FRAMES = 32,
    parameter logic [11:0] BG_COLOR     = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vsync_in,
    input  logic        mouse_left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [11:0] color1,
    output logic [11:0] color2,
    output logic        active,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCROLL = 3'd1,
        S_PAUSED = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [12:0] c_STEP       = 13'(STEP);
    localparam logic [12:0] c_LIMIT      = {1'b0, STOP_Y} + c_STEP;
    localparam logic [15:0] c_HOLD_LAST  = 16'(HOLD_FRAMES - 1);
    localparam logic [15:0] c_COLOR_LAST = 16'(COLOR_FRAMES - 1);

    state_t      state_q, state_d;
    logic [11:0] ypos_q, ypos_d;
    logic [11:0] xpos_q, color1_q, color1_d, color2_q;
    logic        active_q, active_d, done_q, done_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [15:0] col_cnt_q, col_cnt_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic        vsync_dly_q, tick_q, tick_d;
    logic        msync1_q, msync2_q, msync3_q, click_q, click_d;
    logic        w_col_adv;

    function automatic logic [11:0] palette(input logic [1:0] idx);
        case (idx)
            2'd0:    palette = 12'hFFF;
            2'd1:    palette = 12'hFF0;
            2'd2:    palette = 12'h0FF;
            default: palette = 12'hF0F;
        endcase
    endfunction

    always_comb begin
        tick_d     = vsync_in & ~vsync_dly_q;
        click_d    = msync2_q & ~msync3_q;
        state_d    = state_q;
        ypos_d     = ypos_q;
        hold_cnt_d = hold_cnt_q;
        col_cnt_d  = col_cnt_q;
        col_idx_d  = col_idx_q;
        w_col_adv  = 1'b0;

        if (!enable) begin
            state_d    = S_IDLE;
            ypos_d     = START_Y;
            hold_cnt_d = 16'd0;
            col_cnt_d  = 16'd0;
            col_idx_d  = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ypos_d     = START_Y;
                    hold_cnt_d = 16'd0;
                    col_cnt_d  = 16'd0;
                    col_idx_d  = 2'd0;
                    state_d    = S_SCROLL;
                end
                S_SCROLL: begin
                    // A click in the same cycle as a frame tick pauses without moving
                    if (click_q) begin
                        state_d = S_PAUSED;
                    end else if (tick_q) begin
                        w_col_adv = 1'b1;
                        if ({1'b0, ypos_q} <= c_LIMIT) begin
                            ypos_d     = STOP_Y;
                            hold_cnt_d = 16'd0;
                            state_d    = S_HOLD;
                        end else begin
                            ypos_d = ypos_q - c_STEP[11:0];
                        end
                    end
                end
                S_PAUSED: begin
                    if (click_q) state_d = S_SCROLL;
                end
                S_HOLD: begin
                    if (click_q) begin
                        state_d = S_DONE;
                    end else if (tick_q) begin
                        w_col_adv = 1'b1;
                        if (hold_cnt_q >= c_HOLD_LAST) state_d = S_DONE;
                        else hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
                S_DONE: begin
                    ypos_d = STOP_Y;
                end
                default: begin
                    state_d = S_IDLE;
                    ypos_d  = START_Y;
                end
            endcase
        end

        if (w_col_adv) begin
            if (col_cnt_q >= c_COLOR_LAST) begin
                col_cnt_d = 16'd0;
                col_idx_d = col_idx_q + 2'd1;
            end else begin
                col_cnt_d = col_cnt_q + 16'd1;
            end
        end

        active_d = (state_d == S_SCROLL) || (state_d == S_PAUSED) || (state_d == S_HOLD);
        done_d   = (state_d == S_DONE);
        color1_d = palette(col_idx_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ypos_q      <= START_Y;
            xpos_q      <= X_POS;
            color1_q    <= 12'hFFF;
            color2_q    <= BG_COLOR;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            hold_cnt_q  <= 16'd0;
            col_cnt_q   <= 16'd0;
            col_idx_q   <= 2'd0;
            vsync_dly_q <= 1'b0;
            tick_q      <= 1'b0;
            msync1_q    <= 1'b0;
            msync2_q    <= 1'b0;
            msync3_q    <= 1'b0;
            click_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ypos_q      <= ypos_d;
            xpos_q      <= X_POS;
            color1_q    <= color1_d;
            color2_q    <= BG_COLOR;
            active_q    <= active_d;
            done_q      <= done_d;
            hold_cnt_q  <= hold_cnt_d;
            col_cnt_q   <= col_cnt_d;
            col_idx_q   <= col_idx_d;
            vsync_dly_q <= vsync_in;
            tick_q      <= tick_d;
            msync1_q    <= mouse_left;
            msync2_q    <= msync1_q;
            msync3_q    <= msync2_q;
            click_q     <= click_d;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign color1 = color1_q;
    assign color2 = color2_q;
    assign active = active_q;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cred_scroll_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cred_scroll_ctl
// Brief   : Self-checking bench for cred_scroll_ctl (default and STEP=7 builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cred_scroll_ctl;

    logic        clk = 1'b0;
    logic        rst, enable, vsync_in, mouse_left;
    logic [11:0] xpos, ypos, color1, color2;
    logic        active, done;
    logic [11:0] xpos7, ypos7, color1_7, color2_7;
    logic        active7, done7;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cred_scroll_ctl dut (
        .clk(clk), .rst(rst), .enable(enable), .vsync_in(vsync_in),
        .mouse_left(mouse_left), .xpos(xpos), .ypos(ypos), .color1(color1),
        .color2(color2), .active(active), .done(done)
    );

    cred_scroll_ctl #(.STEP(7)) dut7 (
        .clk(clk), .rst(rst), .enable(enable), .vsync_in(vsync_in),
        .mouse_left(mouse_left), .xpos(xpos7), .ypos(ypos7), .color1(color1_7),
        .color2(color2_7), .active(active7), .done(done7)
    );

    typedef struct {
        string       name;
        bit          en;
        bit          do_click;
        int          ticks;
        logic [11:0] y;
        logic [11:0] c1;
        bit          act;
        bit          dn;
        logic [11:0] y7;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic frame();
        @(negedge clk) vsync_in = 1'b1;
        repeat (2) @(negedge clk);
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic click();
        @(negedge clk) mouse_left = 1'b1;
        repeat (4) @(negedge clk);
        mouse_left = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cumulative scenario: each row acts on the state left by the previous one
        vecs[0]  = '{"start",     1, 0, 0,  12'd600, 12'hFFF, 1, 0, 12'd600};
        vecs[1]  = '{"tick1",     1, 0, 1,  12'd596, 12'hFFF, 1, 0, 12'd593};
        vecs[2]  = '{"tick10",    1, 0, 9,  12'd560, 12'hFFF, 1, 0, 12'd530};
        vecs[3]  = '{"pause",     1, 1, 0,  12'd560, 12'hFFF, 1, 0, 12'd530};
        vecs[4]  = '{"paused30",  1, 0, 30, 12'd560, 12'hFFF, 1, 0, 12'd530};
        vecs[5]  = '{"resume",    1, 1, 1,  12'd556, 12'hFFF, 1, 0, 12'd523};
        vecs[6]  = '{"colour1",   1, 0, 21, 12'd472, 12'hFF0, 1, 0, 12'd376};
        vecs[7]  = '{"tick57",    1, 0, 25, 12'd372, 12'hFF0, 1, 0, 12'd201};
        vecs[8]  = '{"tick58",    1, 0, 1,  12'd368, 12'hFF0, 1, 0, 12'd200};
        vecs[9]  = '{"colour2",   1, 0, 6,  12'd344, 12'h0FF, 1, 0, 12'd200};
        vecs[10] = '{"colour3",   1, 0, 32, 12'd216, 12'hF0F, 1, 0, 12'd200};
        vecs[11] = '{"tick99",    1, 0, 3,  12'd204, 12'hF0F, 1, 0, 12'd200};
        vecs[12] = '{"hold",      1, 0, 1,  12'd200, 12'hF0F, 1, 0, 12'd200};
        vecs[13] = '{"colour4",   1, 0, 28, 12'd200, 12'hFFF, 1, 0, 12'd200};
        vecs[14] = '{"hold119",   1, 0, 91, 12'd200, 12'h0FF, 1, 0, 12'd200};
        vecs[15] = '{"hold120",   1, 0, 1,  12'd200, 12'h0FF, 0, 1, 12'd200};
        vecs[16] = '{"done_clk",  1, 1, 0,  12'd200, 12'h0FF, 0, 1, 12'd200};
        vecs[17] = '{"abort",     0, 0, 0,  12'd600, 12'hFFF, 0, 0, 12'd600};

        rst = 1'b0; enable = 1'b0; vsync_in = 1'b0; mouse_left = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_xpos",   32'(xpos),   32'd400);
        chk("rst_ypos",   32'(ypos),   32'd600);
        chk("rst_color1", 32'(color1), 32'hFFF);
        chk("rst_color2", 32'(color2), 32'h000);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_done",   32'(done),   32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_active", 32'(active), 32'd0);

        for (int v = 0; v < 18; v++) begin
            @(negedge clk) enable = vecs[v].en;
            if (vecs[v].do_click) click();
            frames(vecs[v].ticks);
            repeat (2) @(negedge clk);
            chk({vecs[v].name, "_ypos"},   32'(ypos),   32'(vecs[v].y));
            chk({vecs[v].name, "_color1"}, 32'(color1), 32'(vecs[v].c1));
            chk({vecs[v].name, "_color2"}, 32'(color2), 32'h000);
            chk({vecs[v].name, "_xpos"},   32'(xpos),   32'd400);
            chk({vecs[v].name, "_active"}, 32'(active), 32'(vecs[v].act));
            chk({vecs[v].name, "_done"},   32'(done),   32'(vecs[v].dn));
            chk({vecs[v].name, "_ypos7"},  32'(ypos7),  32'(vecs[v].y7));
        end

        // Reset in the middle of a scroll, enable held high
        @(negedge clk) enable = 1'b1;
        repeat (2) @(negedge clk);
        frames(5);
        chk("pre_rst_ypos", 32'(ypos), 32'd580);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ypos",   32'(ypos),   32'd600);
        chk("midrst_active", 32'(active), 32'd0);
        chk("midrst_color1", 32'(color1), 32'hFFF);
        chk("midrst_done",   32'(done),   32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_active", 32'(active), 32'd1);
        chk("post_rst_ypos",   32'(ypos),   32'd600);

        // Click and frame tick land in the same cycle
        mouse_left = 1'b1;
        @(negedge clk);
        @(negedge clk) vsync_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vsync_in = 1'b0; mouse_left = 1'b0;
        repeat (4) @(negedge clk);
        chk("simul_ypos", 32'(ypos), 32'd600);
        frame();
        chk("simul_paused_ypos", 32'(ypos), 32'd600);
        click();
        frame();
        chk("simul_resume_ypos", 32'(ypos), 32'd596);

        // A held button yields a single click
        @(negedge clk) mouse_left = 1'b1;
        repeat (6) @(negedge clk);
        frames(3);
        chk("held_ypos", 32'(ypos), 32'd596);
        mouse_left = 1'b0;
        repeat (4) @(negedge clk);
        frame();
        chk("held_once_ypos", 32'(ypos), 32'd596);
        click();
        frame();
        chk("held_resume_ypos", 32'(ypos), 32'd592);

        // Skip from HOLD: exact click latency
        frames(98);
        chk("hold2_ypos",   32'(ypos),   32'd200);
        chk("hold2_active", 32'(active), 32'd1);
        chk("hold2_done",   32'(done),   32'd0);
        @(negedge clk) mouse_left = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("skip_n2_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("skip_n3_done",   32'(done),   32'd1);
        chk("skip_n3_active", 32'(active), 32'd0);
        mouse_left = 1'b0;

        // Abort: IDLE on the very next edge
        @(negedge clk) enable = 1'b0;
        @(negedge clk);
        chk("abort_ypos",   32'(ypos),   32'd600);
        chk("abort_active", 32'(active), 32'd0);
        chk("abort_done",   32'(done),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
